// File: rtl/ts_packet_sync_if.sv
// Byte-stream interface for the TS synchronizer: raw TS bytes in, framed packet bytes out.
// The slave modport is the synchronizer's view; master is the surrounding source/sink.
interface ts_packet_sync_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  valid;
    logic [DATA_WIDTH-1:0] byte_data;
    logic                  pkt_valid;
    logic [DATA_WIDTH-1:0] pkt_data;
    logic                  pkt_sop;
    logic                  pkt_eop;
    logic                  sync_err;

    modport master (
        output valid,
        output byte_data,
        input  pkt_valid,
        input  pkt_data,
        input  pkt_sop,
        input  pkt_eop,
        input  sync_err
    );

    modport slave (
        input  valid,
        input  byte_data,
        output pkt_valid,
        output pkt_data,
        output pkt_sop,
        output pkt_eop,
        output sync_err
    );
endinterface

// File: rtl/ts_packet_sync.sv
// MPEG-2 TS byte-stream synchronizer: hunts for the sync byte, verifies periodic alignment,
// then emits framed packets with header fields, flywheel error marking and statistics.
module ts_packet_sync #(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    PKT_LEN       = 188,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE     = 8'h47,
    parameter int                    LOCK_THRESH   = 3,
    parameter int                    UNLOCK_THRESH = 3,
    parameter int                    CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    ts_packet_sync_if.slave      bus,
    output logic                 locked,
    output logic                 hdr_valid,
    output logic                 tei,
    output logic [12:0]          pid,
    output logic [3:0]           cc,
    output logic                 sync_loss,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic [CNT_WIDTH-1:0] loss_count
);

    localparam int BW = $clog2(PKT_LEN);
    localparam int GW = $clog2(LOCK_THRESH + 1);
    localparam int XW = $clog2(UNLOCK_THRESH + 1);
    localparam logic [BW-1:0] LAST_POS = BW'(PKT_LEN - 1);
    localparam logic [GW-1:0] LOCK_N   = GW'(LOCK_THRESH);
    localparam logic [XW-1:0] UNLOCK_N = XW'(UNLOCK_THRESH);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [GW-1:0] good_cnt_q, good_cnt_d, good_inc;
    logic [XW-1:0] bad_cnt_q, bad_cnt_d, bad_inc;
    logic          pkt_err_q, pkt_err_d;
    logic          hdr_tei_q;
    logic [4:0]    hdr_pid_hi_q;
    logic [7:0]    hdr_pid_lo_q;
    logic          is_sync, at_sync, emit, drop_lock, err_now;

    assign is_sync  = (bus.byte_data == SYNC_BYTE);
    assign at_sync  = (byte_cnt_q == '0);
    assign good_inc = good_cnt_q + GW'(1);
    assign bad_inc  = bad_cnt_q + XW'(1);
    assign locked   = (state_q == LOCKED);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.valid) begin
            case (state_q)
                HUNT: begin
                    if (is_sync) state_d = VERIFY;
                end
                VERIFY: begin
                    if (at_sync) begin
                        if (!is_sync)               state_d = HUNT;
                        else if (good_inc == LOCK_N) state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (at_sync && !is_sync && (bad_inc == UNLOCK_N)) state_d = HUNT;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // The byte that completes the lock is emitted; the byte that drops lock is not.
    always_comb begin
        emit       = bus.valid && (state_d == LOCKED);
        drop_lock  = bus.valid && (state_q == LOCKED) && (state_d == HUNT);
        err_now    = at_sync ? !is_sync : pkt_err_q;
        byte_cnt_d = byte_cnt_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        pkt_err_d  = pkt_err_q;
        if (bus.valid) begin
            if (state_d == HUNT) begin
                byte_cnt_d = '0;
                good_cnt_d = '0;
                bad_cnt_d  = '0;
                pkt_err_d  = 1'b0;
            end else begin
                if (state_q == HUNT)            byte_cnt_d = BW'(1);
                else if (byte_cnt_q == LAST_POS) byte_cnt_d = '0;
                else                             byte_cnt_d = byte_cnt_q + BW'(1);

                if (state_q == HUNT)                  good_cnt_d = GW'(1);
                else if (state_q == VERIFY && at_sync) good_cnt_d = good_inc;

                if (state_q == LOCKED && at_sync) begin
                    bad_cnt_d = is_sync ? '0 : bad_inc;
                    pkt_err_d = !is_sync;
                end else if (state_q != LOCKED) begin
                    bad_cnt_d = '0;
                    pkt_err_d = 1'b0;
                end
            end
        end
    end

    // Header bytes 1 and 2 are staged so all three fields publish together with byte 3.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_cnt_q    <= '0;
            good_cnt_q    <= '0;
            bad_cnt_q     <= '0;
            pkt_err_q     <= 1'b0;
            hdr_tei_q     <= 1'b0;
            hdr_pid_hi_q  <= '0;
            hdr_pid_lo_q  <= '0;
            bus.pkt_valid <= 1'b0;
            bus.pkt_data  <= '0;
            bus.pkt_sop   <= 1'b0;
            bus.pkt_eop   <= 1'b0;
            bus.sync_err  <= 1'b0;
            hdr_valid     <= 1'b0;
            tei           <= 1'b0;
            pid           <= '0;
            cc            <= '0;
            sync_loss     <= 1'b0;
            pkt_count     <= '0;
            loss_count    <= '0;
        end else begin
            byte_cnt_q    <= byte_cnt_d;
            good_cnt_q    <= good_cnt_d;
            bad_cnt_q     <= bad_cnt_d;
            pkt_err_q     <= pkt_err_d;
            bus.pkt_valid <= emit;
            bus.pkt_sop   <= emit && at_sync;
            bus.pkt_eop   <= emit && (byte_cnt_q == LAST_POS);
            bus.sync_err  <= emit && err_now;
            hdr_valid     <= emit && (byte_cnt_q == BW'(3));
            sync_loss     <= drop_lock;
            if (emit) begin
                bus.pkt_data <= bus.byte_data;
                if (byte_cnt_q == BW'(1)) begin
                    hdr_tei_q    <= bus.byte_data[7];
                    hdr_pid_hi_q <= bus.byte_data[4:0];
                end
                if (byte_cnt_q == BW'(2)) hdr_pid_lo_q <= bus.byte_data[7:0];
                if (byte_cnt_q == BW'(3)) begin
                    tei <= hdr_tei_q;
                    pid <= {hdr_pid_hi_q, hdr_pid_lo_q};
                    cc  <= bus.byte_data[3:0];
                end
                if ((byte_cnt_q == LAST_POS) && (pkt_count != '1)) pkt_count <= pkt_count + CNT_WIDTH'(1);
            end
            if (drop_lock && (loss_count != '1)) loss_count <= loss_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_ts_packet_sync.sv
// Scoreboard bench for ts_packet_sync: directed packet streams push expected beats/headers,
// a negedge monitor pops and compares whatever the synchronizer emits.
module tb_ts_packet_sync;

    localparam int PKT_LEN = 188;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       err;
        logic       hdr;
    } beat_t;

    typedef struct packed {
        logic        tei;
        logic [12:0] pid;
        logic [3:0]  cc;
    } hdr_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        locked, hdr_valid, tei, sync_loss;
    logic [12:0] pid;
    logic [3:0]  cc;
    logic [15:0] pkt_count, loss_count;

    int    compared = 0;
    int    mismatched = 0;
    int    lossPulses = 0;
    int    pktSeed = 0;
    logic  lastValid = 1'b0;
    beat_t expQ[$];
    hdr_t  hdrQ[$];
    beat_t gotBeat, expBeat;
    hdr_t  gotHdr, expHdr;

    always #5 clk = ~clk;

    ts_packet_sync_if #(.DATA_WIDTH(8)) bus ();

    ts_packet_sync #(
        .DATA_WIDTH   (8),
        .PKT_LEN      (PKT_LEN),
        .SYNC_BYTE    (8'h47),
        .LOCK_THRESH  (3),
        .UNLOCK_THRESH(3),
        .CNT_WIDTH    (16)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .locked    (locked),
        .hdr_valid (hdr_valid),
        .tei       (tei),
        .pid       (pid),
        .cc        (cc),
        .sync_loss (sync_loss),
        .pkt_count (pkt_count),
        .loss_count(loss_count)
    );

    always @(posedge clk) lastValid = bus.valid;

    // Monitor: every emitted beat must match the next queued expectation and follow a valid input.
    always @(negedge clk) begin
        if (sync_loss) lossPulses++;
        if (bus.pkt_valid) begin
            gotBeat.data = bus.pkt_data;
            gotBeat.sop  = bus.pkt_sop;
            gotBeat.eop  = bus.pkt_eop;
            gotBeat.err  = bus.sync_err;
            gotBeat.hdr  = hdr_valid;
            compared++;
            if (expQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL beat: unexpected output data=%h sop=%b eop=%b, required no output",
                         gotBeat.data, gotBeat.sop, gotBeat.eop);
            end else begin
                expBeat = expQ.pop_front();
                if ((gotBeat !== expBeat) || !lastValid) begin
                    mismatched++;
                    $display("[TB] FAIL beat: got data=%h sop=%b eop=%b err=%b hdr=%b inValid=%b, required data=%h sop=%b eop=%b err=%b hdr=%b inValid=1",
                             gotBeat.data, gotBeat.sop, gotBeat.eop, gotBeat.err, gotBeat.hdr, lastValid,
                             expBeat.data, expBeat.sop, expBeat.eop, expBeat.err, expBeat.hdr);
                end
            end
        end else if (hdr_valid) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL hdr_strobe: hdr_valid=1 with pkt_valid=0, required hdr_valid=0");
        end
        if (hdr_valid) begin
            gotHdr.tei = tei;
            gotHdr.pid = pid;
            gotHdr.cc  = cc;
            compared++;
            if (hdrQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL hdr: unexpected header tei=%b pid=%h cc=%h", tei, pid, cc);
            end else begin
                expHdr = hdrQ.pop_front();
                if (gotHdr !== expHdr) begin
                    mismatched++;
                    $display("[TB] FAIL hdr: got tei=%b pid=%h cc=%h, required tei=%b pid=%h cc=%h",
                             tei, pid, cc, expHdr.tei, expHdr.pid, expHdr.cc);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic driveByte(input logic [7:0] b, input int gapPct);
        while (gapPct > 0 && int'($urandom_range(0, 99)) < gapPct) begin
            bus.valid = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.valid     = 1'b1;
        bus.byte_data = b;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] syncb, input logic [7:0] b1, input logic [7:0] b2,
                                 input logic [7:0] b3, input bit expOut, input bit expErr,
                                 input int gapPct = 0, input int startIdx = 0,
                                 input int nBytes = PKT_LEN, input int lockChk = -1);
        for (int i = startIdx; i < startIdx + nBytes; i++) begin
            logic [7:0] b;
            beat_t      e;
            hdr_t       h;
            case (i)
                0:       b = syncb;
                1:       b = b1;
                2:       b = b2;
                3:       b = b3;
                default: b = 8'(((i * 3) + pktSeed) & 'h3F);
            endcase
            if (expOut) begin
                e.data = b;
                e.sop  = (i == 0);
                e.eop  = (i == PKT_LEN - 1);
                e.err  = expErr;
                e.hdr  = (i == 3);
                expQ.push_back(e);
                if (i == 3) begin
                    h.tei = b1[7];
                    h.pid = {b1[4:0], b2};
                    h.cc  = b3[3:0];
                    hdrQ.push_back(h);
                end
            end
            driveByte(b, gapPct);
            if (i == 0 && lockChk >= 0) checkOutput("locked_after_sync", 32'(locked), 32'(lockChk));
        end
        if (startIdx + nBytes == PKT_LEN) pktSeed++;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((expQ.size() != 0 || hdrQ.size() != 0) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        checkOutput("drain_beats", 32'(expQ.size()), 32'd0);
        checkOutput("drain_headers", 32'(hdrQ.size()), 32'd0);
    endtask

    task automatic doReset();
        waitDrain();
        @(negedge clk);
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        pktSeed    = 0;
        lossPulses = 0;
    endtask

    task automatic cleanRun(input int gapPct);
        applyStimulus(8'h47, 8'h01, 8'h00, 8'h10, 1'b0, 1'b0, gapPct);
        applyStimulus(8'h47, 8'h01, 8'h00, 8'h10, 1'b0, 1'b0, gapPct, 0, PKT_LEN, 0);
        applyStimulus(8'h47, 8'h01, 8'h00, 8'h10, 1'b1, 1'b0, gapPct, 0, PKT_LEN, 1);
        applyStimulus(8'h47, 8'h01, 8'h00, 8'h10, 1'b1, 1'b0, gapPct);
        applyStimulus(8'h47, 8'h01, 8'h00, 8'h10, 1'b1, 1'b0, gapPct);
        waitDrain();
        checkOutput("clean_pkt_count", 32'(pkt_count), 32'd3);
        checkOutput("clean_locked", 32'(locked), 32'd1);
    endtask

    initial begin
        #2_000_000;
        mismatched++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.valid     = 1'b0;
        bus.byte_data = 8'h00;
        rstn          = 1'b0;
        #12;
        checkOutput("reset_locked", 32'(locked), 32'd0);
        checkOutput("reset_pkt_valid", 32'(bus.pkt_valid), 32'd0);
        checkOutput("reset_pkt_count", 32'(pkt_count), 32'd0);
        checkOutput("reset_loss_count", 32'(loss_count), 32'd0);
        checkOutput("reset_sync_loss", 32'(sync_loss), 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] clean lock");
        cleanRun(0);

        $display("[TB] header extraction");
        applyStimulus(8'h47, 8'h5F, 8'hFF, 8'h1A, 1'b1, 1'b0);
        waitDrain();
        checkOutput("hdr1_pid", 32'(pid), 32'h1FFF);
        checkOutput("hdr1_tei", 32'(tei), 32'd0);
        checkOutput("hdr1_cc", 32'(cc), 32'hA);
        applyStimulus(8'h47, 8'h80, 8'h11, 8'h03, 1'b1, 1'b0);
        waitDrain();
        checkOutput("hdr2_pid", 32'(pid), 32'h0011);
        checkOutput("hdr2_tei", 32'(tei), 32'd1);
        checkOutput("hdr2_cc", 32'(cc), 32'h3);
        checkOutput("hdr_pkt_count", 32'(pkt_count), 32'd5);

        $display("[TB] valid gaps");
        doReset();
        cleanRun(30);

        $display("[TB] false sync");
        doReset();
        for (int i = 0; i < 100; i++) driveByte((i == 50) ? 8'h47 : 8'h11, 0);
        applyStimulus(8'h47, 8'h01, 8'h00, 8'h10, 1'b0, 1'b0);
        applyStimulus(8'h47, 8'h01, 8'h00, 8'h10, 1'b0, 1'b0);
        applyStimulus(8'h47, 8'h01, 8'h00, 8'h10, 1'b0, 1'b0, 0, 0, PKT_LEN, 0);
        checkOutput("false_sync_unlocked", 32'(locked), 32'd0);
        applyStimulus(8'h47, 8'h01, 8'h00, 8'h10, 1'b1, 1'b0, 0, 0, PKT_LEN, 1);
        applyStimulus(8'h47, 8'h01, 8'h00, 8'h10, 1'b1, 1'b0);
        applyStimulus(8'h47, 8'h01, 8'h00, 8'h10, 1'b1, 1'b0);
        waitDrain();
        checkOutput("false_sync_pkt_count", 32'(pkt_count), 32'd3);

        $display("[TB] flywheel then loss");
        doReset();
        applyStimulus(8'h47, 8'h01, 8'h00, 8'h10, 1'b0, 1'b0);
        applyStimulus(8'h47, 8'h01, 8'h00, 8'h10, 1'b0, 1'b0);
        applyStimulus(8'h47, 8'h01, 8'h00, 8'h10, 1'b1, 1'b0);
        applyStimulus(8'h00, 8'h01, 8'h00, 8'h10, 1'b1, 1'b1);
        applyStimulus(8'h00, 8'h01, 8'h00, 8'h10, 1'b1, 1'b1, 0, 0, PKT_LEN, 1);
        applyStimulus(8'h47, 8'h01, 8'h00, 8'h10, 1'b1, 1'b0);
        applyStimulus(8'h00, 8'h01, 8'h00, 8'h10, 1'b1, 1'b1);
        applyStimulus(8'h00, 8'h01, 8'h00, 8'h10, 1'b1, 1'b1, 0, 0, PKT_LEN, 1);
        applyStimulus(8'h00, 8'h01, 8'h00, 8'h10, 1'b0, 1'b0, 0, 0, PKT_LEN, 0);
        waitDrain();
        checkOutput("loss_pulses", 32'(lossPulses), 32'd1);
        checkOutput("loss_count", 32'(loss_count), 32'd1);
        checkOutput("loss_locked", 32'(locked), 32'd0);
        applyStimulus(8'h47, 8'h01, 8'h00, 8'h10, 1'b0, 1'b0);
        applyStimulus(8'h47, 8'h01, 8'h00, 8'h10, 1'b0, 1'b0);
        applyStimulus(8'h47, 8'h01, 8'h00, 8'h10, 1'b1, 1'b0, 0, 0, PKT_LEN, 1);
        waitDrain();
        checkOutput("relock_pkt_count", 32'(pkt_count), 32'd7);
        checkOutput("relock_loss_pulses", 32'(lossPulses), 32'd1);

        $display("[TB] reset mid-packet");
        doReset();
        applyStimulus(8'h47, 8'h5F, 8'hFF, 8'h1A, 1'b0, 1'b0);
        applyStimulus(8'h47, 8'h5F, 8'hFF, 8'h1A, 1'b0, 1'b0);
        applyStimulus(8'h47, 8'h5F, 8'hFF, 8'h1A, 1'b1, 1'b0);
        applyStimulus(8'h47, 8'h5F, 8'hFF, 8'h1A, 1'b1, 1'b0, 0, 0, 100);
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("async_locked", 32'(locked), 32'd0);
        checkOutput("async_pkt_valid", 32'(bus.pkt_valid), 32'd0);
        checkOutput("async_pkt_data", 32'(bus.pkt_data), 32'd0);
        checkOutput("async_pkt_count", 32'(pkt_count), 32'd0);
        checkOutput("async_loss_count", 32'(loss_count), 32'd0);
        checkOutput("async_pid", 32'(pid), 32'd0);
        checkOutput("async_cc", 32'(cc), 32'd0);
        #20;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(8'h47, 8'h5F, 8'hFF, 8'h1A, 1'b0, 1'b0, 0, 100, PKT_LEN - 100);
        applyStimulus(8'h47, 8'h01, 8'h00, 8'h10, 1'b0, 1'b0);
        applyStimulus(8'h47, 8'h01, 8'h00, 8'h10, 1'b0, 1'b0, 0, 0, PKT_LEN, 0);
        applyStimulus(8'h47, 8'h01, 8'h00, 8'h10, 1'b1, 1'b0, 0, 0, PKT_LEN, 1);
        waitDrain();
        checkOutput("post_reset_pkt_count", 32'(pkt_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ts_packet_sync.md
Name: ts_packet_sync

Overview:
- Per-channel MPEG-2 TS byte-stream synchronizer. Sits directly downstream of the TS byte source: one `byte_data` lane plus its `valid` bit.
- Hunts for the 0x47 sync byte and confirms lock on periodic sync bytes spaced every PKT_LEN bytes.
- Once locked, emits framed packets with start/end markers, extracted header fields, sync-loss events and packet/loss counters.
- One instance per channel; feeds the QoS error-detection stage.

Parameters:
- DATA_WIDTH, 8, byte lane width.
- PKT_LEN, 188, TS packet length in bytes.
- SYNC_BYTE, 8'h47, sync byte value.
- LOCK_THRESH, 3, consecutive correctly spaced sync bytes needed to lock (≥2).
- UNLOCK_THRESH, 3, consecutive missing sync bytes at expected position needed to drop lock (≥1).
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset. Asynchronous, active-low.
- valid  in  1  byte_data qualifier.
- byte_data  in  DATA_WIDTH  TS stream byte.
- locked  out  1  high while FSM is in LOCKED.
- pkt_valid  out  1  pkt_data qualifier.
- pkt_data  out  DATA_WIDTH  framed packet byte.
- pkt_sop  out  1  marks byte index 0.
- pkt_eop  out  1  marks byte index PKT_LEN-1.
- sync_err  out  1  qualifies the current output packet: its sync byte was not SYNC_BYTE (flywheel packet).
- hdr_valid  out  1  one-cycle pulse; pid/tei/cc are valid.
- tei  out  1  transport error indicator.
- pid  out  13  packet identifier.
- cc  out  4  continuity counter.
- sync_loss  out  1  one-cycle pulse on LOCKED->HUNT.
- pkt_count  out  CNT_WIDTH  packets emitted, saturating.
- loss_count  out  CNT_WIDTH  sync-loss events, saturating.

Behaviour:
- **Reset.** On rstn low, immediately: state=HUNT, all outputs 0, internal counters 0. Reset takes effect mid-packet with no completion of the partial packet.
- **Stall.** Only cycles with valid=1 advance anything. With valid=0 there is no state or counter change and pkt_valid=0.
- **byte_cnt.** Position 0..PKT_LEN-1 of the current byte relative to the last sync position; wraps PKT_LEN-1 -> 0.
- **HUNT.**
  - A valid byte == SYNC_BYTE -> VERIFY, with good_cnt=1 and the next byte at position 1.
  - Any other byte stays in HUNT.
  - No output in HUNT.
- **VERIFY.**
  - At each expected sync position (byte_cnt=0) with byte == SYNC_BYTE: good_cnt++.
  - If the incremented good_cnt == LOCK_THRESH -> LOCKED. This sync byte is the first output byte, with pkt_sop.
  - At an expected sync position with byte != SYNC_BYTE -> HUNT. That byte is not re-examined.
  - A 0x47 at a non-sync position is ignored.
  - No output in VERIFY.
- **LOCKED output.**
  - Every valid byte is output: pkt_data/pkt_valid registered, latency 1 cycle.
  - pkt_sop with byte_cnt=0; pkt_eop with byte_cnt=PKT_LEN-1.
  - pkt_count increments on each pkt_eop and saturates at all-ones.
- **LOCKED sync checking.**
  - At byte_cnt=0, byte == SYNC_BYTE: bad_cnt=0, sync_err=0 for this packet.
  - At byte_cnt=0, byte != SYNC_BYTE: bad_cnt++.
  - If the incremented bad_cnt < UNLOCK_THRESH: the packet is still output (flywheel) with sync_err=1, held from sop through eop.
  - If the incremented bad_cnt == UNLOCK_THRESH: -> HUNT, sync_loss pulses on the next edge, and loss_count increments (saturating).
  - The offending byte is not output, so lock loss always occurs on a packet boundary. No partial packets are ever emitted.
- **Header extraction** (LOCKED only):
  - tei = byte1[7]; pid = {byte1[4:0], byte2}; cc = byte3[3:0].
  - hdr_valid pulses in the same cycle pkt_data presents byte 3.
  - pid/tei/cc hold their values until the next update.
- **Simultaneous events.** HUNT on the final unlock byte re-arms on the next valid byte; the dropped byte is not a lock candidate.
- **locked** is registered and equals (state==LOCKED).

Test Plan:
- **Clean lock.** Contiguous stream, 5 packets, PKT_LEN=188, LOCK_THRESH=3.
  - locked rises 1 cycle after the 3rd sync byte.
  - Exactly 3 packets are output (the 3rd–5th input packets).
  - pkt_count=3; each sop/eop 187 valid bytes apart.
- **Header extraction.** Packet bytes 47 5F FF 1A.
  - hdr_valid coincides with the pkt_data=0x1A output cycle.
  - pid=0x1FFF, tei=0, cc=0xA.
  - Bytes 47 80 11 03 -> tei=1, pid=0x0011, cc=3.
- **False sync.** Leading garbage with a payload 0x47 at offset 50 not repeated 188 bytes later.
  - FSM returns to HUNT.
  - Lock is achieved only on the true alignment, with no output before it.
- **Flywheel then loss.**
  - Corrupt 2 consecutive sync bytes (UNLOCK_THRESH=3): both packets are output with sync_err=1, locked stays 1.
  - Corrupt 3 consecutive sync bytes: sync_loss pulses once, loss_count=1, locked=0, no output until re-lock.
- **Valid gaps.** Random valid=0 bubbles (~30%) over a clean stream.
  - Output byte sequence identical to the gap-free run; pkt_valid never asserted on bubble cycles.
- **Reset mid-packet.** Assert rstn=0 at byte 100 of a locked packet.
  - All outputs 0 asynchronously, including the counters.
  - After release, no pkt_valid until a fresh lock.
